// File: rtl/simon_input_capture.sv
// Simon player input path: debounces one-hot colour buttons, hands each
// accepted colour to the controller and packs the entries into a pattern word.
module simon_input_capture #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_LEN         = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [3:0]             level,
   input  logic [3:0]             btn,
   input  logic                   color_ready,
   output logic [1:0]             color_out,
   output logic                   color_valid,
   output logic [2*MAX_LEN-1:0]   pattern_out,
   output logic [3:0]             count,
   output logic                   busy,
   output logic                   done,
   output logic                   err_multi
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] MAX_L = 4'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PRESS,
      DEBOUNCE,
      EMIT,
      WAIT_RELEASE,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           btn_q, btn_d;
   logic [1:0]           code_q, code_d;
   logic [1:0]           color_q, color_d;
   logic [DW-1:0]        cnt_q, cnt_d;
   logic [2*MAX_LEN-1:0] pat_q, pat_d;
   logic [3:0]           count_q, count_d;
   logic [3:0]           lvl_q, lvl_d;
   logic                 err_q, err_d;

   logic       one_hot;
   logic [1:0] enc;
   logic [3:0] lvl_clamp;

   assign one_hot   = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
   // Valid for one-hot input only; B=00, G=01, R=10, Y=11.
   assign enc       = {btn[3] | btn[2], btn[3] | btn[1]};
   assign lvl_clamp = (level > MAX_L) ? MAX_L : level;

   always_comb begin
      state_d = state_q;
      btn_d   = btn_q;
      code_d  = code_q;
      color_d = color_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      count_d = count_q;
      lvl_d   = lvl_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pat_d   = '0;
               count_d = 4'd0;
               lvl_d   = lvl_clamp;
               state_d = (lvl_clamp == 4'd0) ? DONE : WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            if (one_hot) begin
               btn_d   = btn;
               code_d  = enc;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end else if (btn != 4'd0) begin
               err_d   = 1'b1;
               state_d = WAIT_RELEASE;
            end
         end
         DEBOUNCE: begin
            if (btn == btn_q) begin
               if (cnt_q == DB_LAST) begin
                  color_d = code_q;
                  state_d = EMIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               state_d = WAIT_PRESS;
            end
         end
         EMIT: begin
            if (color_ready) begin
               for (int k = 0; k < MAX_LEN; k++) begin
                  if (count_q == 4'(k)) pat_d[2*k +: 2] = code_q;
               end
               count_d = count_q + 4'd1;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (btn == 4'd0)
               state_d = (count_q == lvl_q) ? DONE : WAIT_PRESS;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         btn_q   <= 4'd0;
         code_q  <= 2'd0;
         color_q <= 2'd0;
         cnt_q   <= '0;
         pat_q   <= '0;
         count_q <= 4'd0;
         lvl_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn_d;
         code_q  <= code_d;
         color_q <= color_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         count_q <= count_d;
         lvl_q   <= lvl_d;
         err_q   <= err_d;
      end
   end

   assign color_out   = color_q;
   assign color_valid = (state_q == EMIT);
   assign pattern_out = pat_q;
   assign count       = count_q;
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);
   assign err_multi   = err_q;

endmodule
